// File: rtl/alu_issue_stage.sv
// Operand-issue stage ahead of alu_gate: architectural register file with
// writeback forwarding, per-register pending scoreboard and one-entry issue register.
module alu_issue_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FUNC_WIDTH = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [FUNC_WIDTH-1:0] func_i,
  input  logic                  wb_en_i,
  input  logic [ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic                  issue_valid_o,
  input  logic                  issue_ready_i,
  output logic [DATA_WIDTH-1:0] rs1_data_o,
  output logic [DATA_WIDTH-1:0] rs2_data_o,
  output logic [FUNC_WIDTH-1:0] func_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

  localparam logic [FUNC_WIDTH-1:0] FUNC_NOT = FUNC_WIDTH'(3);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   pending;
  logic [NUM_REGS-1:0]   pending_nxt;

  logic                  wb_hit_rs1, wb_hit_rs2, wb_hit_rd;
  logic                  pend_rs1, pend_rs2, pend_rd;
  logic                  hazard, slot_free, accept;
  logic [DATA_WIDTH-1:0] rs1_fwd, rs2_fwd;

  // A same-cycle writeback retires the pending bit it targets, so it must not
  // block an instruction that depends on it; it also supplies the operand.
  assign wb_hit_rs1 = wb_en_i && (wb_addr_i == rs1_addr_i);
  assign wb_hit_rs2 = wb_en_i && (wb_addr_i == rs2_addr_i);
  assign wb_hit_rd  = wb_en_i && (wb_addr_i == rd_addr_i);

  assign pend_rs1 = pending[rs1_addr_i] && !wb_hit_rs1;
  assign pend_rs2 = pending[rs2_addr_i] && !wb_hit_rs2;
  assign pend_rd  = pending[rd_addr_i]  && !wb_hit_rd;

  assign hazard = pend_rs1 || ((func_i != FUNC_NOT) && pend_rs2) || pend_rd;

  assign rs1_fwd = (rs1_addr_i == '0) ? '0 : (wb_hit_rs1 ? wb_data_i : regs[rs1_addr_i]);
  assign rs2_fwd = (rs2_addr_i == '0) ? '0 : (wb_hit_rs2 ? wb_data_i : regs[rs2_addr_i]);

  // Handshake: a transfer happens on a clock edge where valid && ready are both
  // high. Ready never looks at valid; valid, once high, holds its payload until
  // the transfer. Upstream: instr_valid_i/instr_ready_o. Downstream:
  // issue_valid_o/issue_ready_i, where the issue register holds while stalled.
  assign slot_free     = !issue_valid_o || issue_ready_i;
  assign instr_ready_o = slot_free && !hazard;
  assign accept        = instr_valid_i && instr_ready_o;

  // Clear on writeback first so that a same-cycle set on accept wins.
  always_comb begin
    pending_nxt = pending;
    if (wb_en_i) begin
      pending_nxt[wb_addr_i] = 1'b0;
    end
    if (accept && (rd_addr_i != '0)) begin
      pending_nxt[rd_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      pending       <= '0;
      issue_valid_o <= 1'b0;
      rs1_data_o    <= '0;
      rs2_data_o    <= '0;
      func_o        <= '0;
      rd_addr_o     <= '0;
      stall_cnt_o   <= '0;
    end else begin
      if (wb_en_i && (wb_addr_i != '0)) begin
        regs[wb_addr_i] <= wb_data_i;
      end
      pending <= pending_nxt;

      if (accept) begin
        issue_valid_o <= 1'b1;
        rs1_data_o    <= rs1_fwd;
        rs2_data_o    <= rs2_fwd;
        func_o        <= func_i;
        rd_addr_o     <= rd_addr_i;
      end else if (issue_ready_i) begin
        issue_valid_o <= 1'b0;
      end

      if (instr_valid_i && slot_free && hazard && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + 1'b1;
      end
    end
  end

endmodule
